// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: receives a framed firmware image over a UART byte stream
// and forwards the payload bytes into a write-domain FIFO.
// Frame layout: SYNC_BYTE, length high, length low, N payload bytes, and an
// 8-bit additive checksum of the payload. The CPU is held in reset (o_busy)
// while a frame is being received.
module uart_load_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         MAX_LEN        = 512,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk_wr,
  input  logic        i_rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_start,
  input  logic        i_fifo_full,
  output logic        o_fifo_valid,
  output logic [7:0]  o_fifo_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_byte_cnt
);

  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]       LEN_MAX = 16'(MAX_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_LEN_H   = 3'd2;
  localparam logic [2:0] S_LEN_L   = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CSUM    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [1:0] E_LEN     = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_CSUM    = 2'b10;
  localparam logic [1:0] E_OVFL    = 2'b11;

  // A length is usable only if at least one byte and no more than the
  // image buffer holds.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && (n <= LEN_MAX);
  endfunction

  // Checksum accumulates modulo 256; the 8-bit wrap is the intended behaviour.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  logic [2:0]      state;
  logic [15:0]     len;
  logic [7:0]      csum;
  logic [15:0]     byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      err_code;
  logic            vld_p1;
  logic [7:0]      data_p1;

  logic            timed;
  logic            to_expire;
  logic            accept;
  logic            last_byte;
  logic            start_ok;

  // The idle timer only guards the part of a frame after the sync byte.
  assign timed     = (state == S_LEN_H) || (state == S_LEN_L) ||
                     (state == S_PAYLOAD) || (state == S_CSUM);
  // A byte in the same cycle as expiry restarts the timer instead of failing.
  assign to_expire = timed && !i_rx_valid && (to_cnt == TO_LAST);
  assign accept    = (state == S_PAYLOAD) && i_rx_valid && !i_fifo_full;
  assign last_byte = accept && ((byte_cnt + 16'd1) == len);
  assign start_ok  = i_start && ((state == S_IDLE) || (state == S_ERR));

  // Idle-cycle counter between received bytes.
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (!timed || i_rx_valid || to_expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Frame parser: walks sync, length, payload and checksum fields.
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      len      <= '0;
      csum     <= '0;
      byte_cnt <= '0;
      err_code <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start_ok) begin
            state    <= S_SYNC;
            len      <= '0;
            csum     <= '0;
            byte_cnt <= '0;
          end
        end
        S_SYNC: begin
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            state <= S_LEN_H;
          end
        end
        S_LEN_H: begin
          if (i_rx_valid) begin
            len[15:8] <= i_rx_data;
            state     <= S_LEN_L;
          end else if (to_expire) begin
            state    <= S_ERR;
            err_code <= E_TIMEOUT;
          end
        end
        S_LEN_L: begin
          if (i_rx_valid) begin
            len[7:0] <= i_rx_data;
            if (len_ok({len[15:8], i_rx_data})) begin
              state <= S_PAYLOAD;
            end else begin
              state    <= S_ERR;
              err_code <= E_LEN;
            end
          end else if (to_expire) begin
            state    <= S_ERR;
            err_code <= E_TIMEOUT;
          end
        end
        S_PAYLOAD: begin
          if (i_rx_valid) begin
            if (i_fifo_full) begin
              state    <= S_ERR;
              err_code <= E_OVFL;
            end else begin
              csum     <= csum_add(csum, i_rx_data);
              byte_cnt <= byte_cnt + 16'd1;
              if (last_byte) begin
                state <= S_CSUM;
              end
            end
          end else if (to_expire) begin
            state    <= S_ERR;
            err_code <= E_TIMEOUT;
          end
        end
        S_CSUM: begin
          if (i_rx_valid) begin
            if (i_rx_data == csum) begin
              state <= S_DONE;
            end else begin
              state    <= S_ERR;
              err_code <= E_CSUM;
            end
          end else if (to_expire) begin
            state    <= S_ERR;
            err_code <= E_TIMEOUT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO write register: one strobe per accepted payload byte, one cycle later.
  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= i_rx_data;
      end
    end
  end

  assign o_fifo_valid = vld_p1;
  assign o_fifo_data  = data_p1;
  assign o_busy       = timed || (state == S_SYNC);
  assign o_done       = (state == S_DONE);
  assign o_err        = (state == S_ERR);
  assign o_err_code   = err_code;
  assign o_byte_cnt   = byte_cnt;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Testbench for uart_load_ctrl: frames are composed at the byte level, the
// expected FIFO writes and terminal events are queued as each frame is built,
// and an independent monitor checks every DUT event against that queue.
module tb_uart_load_ctrl;

  localparam int TO      = 100;
  localparam int MAXL    = 512;
  localparam int K_DATA  = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int val;
    int cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        start = 1'b0;
  logic        full = 1'b0;
  logic        fifo_valid;
  logic [7:0]  fifo_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] byte_cnt;

  ev_t sb[$];
  int  pre[$];
  int  pay[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic err_prev;

  uart_load_ctrl #(
    .SYNC_BYTE(8'h55),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_wr(clk),
    .i_rst_n(rst_n),
    .i_rx_valid(rx_valid),
    .i_rx_data(rx_data),
    .i_start(start),
    .i_fifo_full(full),
    .o_fifo_valid(fifo_valid),
    .o_fifo_data(fifo_data),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_err_code(err_code),
    .o_byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val, input int cnt);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int val, input int cnt);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h cnt=%0d, none expected", kind, val, cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || (kind != K_DATA && e.cnt != cnt)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d val=%0h cnt=%0d expected kind=%0d val=%0h cnt=%0d",
                 kind, val, cnt, e.kind, e.val, e.cnt);
      end
    end
  endtask

  // Monitor: every FIFO write, done pulse and error onset is matched in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      err_prev <= 1'b0;
    end else begin
      if (fifo_valid) check_ev(K_DATA, int'(fifo_data), 0);
      if (done) check_ev(K_DONE, 0, int'(byte_cnt));
      if (err && !err_prev) check_ev(K_ERR, int'(err_code), int'(byte_cnt));
      err_prev <= err;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'(b);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events never seen within %0d cycles", name, sb.size(), limit);
      sb.delete();
    end
  endtask

  function automatic int rand_not_sync();
    int b;
    do b = $urandom_range(255, 0); while (b == 8'h55);
    return b;
  endfunction

  // Send one frame built from pre[] (noise before sync) and pay[] (payload).
  // cs_force < 0 sends the correct checksum; full_at >= 0 raises FIFO full
  // for that payload byte; mid_start pulses i_start halfway through payload.
  task automatic run_frame(input string name, input bit do_start, input int n,
                           input int cs_force, input int full_at,
                           input int gmin, input int gmax, input bit mid_start);
    int sum = 0;
    int cs;
    if (do_start) pulse_start();
    foreach (pre[i]) send(pre[i], 0);
    send(8'h55, 0);
    send((n >> 8) & 255, 0);
    if (n < 1 || n > MAXL) begin
      push(K_ERR, 0, 0);
      send(n & 255, 0);
      drain(name, 20);
      return;
    end
    send(n & 255, 0);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == n / 2) pulse_start();
      if (i == full_at) begin
        push(K_ERR, 3, i);
        full = 1'b1;
        send(pay[i], 0);
        full = 1'b0;
        drain(name, 20);
        return;
      end
      push(K_DATA, pay[i], 0);
      sum += pay[i];
      send(pay[i], $urandom_range(gmax, gmin));
    end
    cs = (cs_force < 0) ? (sum & 255) : cs_force;
    if (cs == (sum & 255)) push(K_DONE, 0, n);
    else push(K_ERR, 2, n);
    send(cs, 0);
    drain(name, 20);
    @(negedge clk);
    chk({name, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back($urandom_range(255, 0));
  endtask

  initial begin
    int n;
    // Reset state.
    #3;
    chk("rst_fifo_valid", int'(fifo_valid), 0);
    chk("rst_fifo_data", int'(fifo_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_byte_cnt", int'(byte_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Bytes in IDLE are ignored.
    send(8'h55, 0); send(8'h00, 0); send(8'h01, 0); send(8'h10, 0);
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Basic three-byte frame.
    pre.delete(); pay = '{8'h11, 8'h22, 8'h33};
    run_frame("basic", 1'b1, 3, 8'h66, -1, 0, 0, 1'b0);
    chk("basic_cnt_hold", int'(byte_cnt), 3);

    // Noise before sync, single byte, bad checksum.
    pre = '{8'hAA}; pay = '{8'h7F};
    run_frame("csum_bad", 1'b1, 1, 8'h00, -1, 0, 0, 1'b0);
    chk("csum_bad_err", int'(err), 1);
    chk("csum_bad_code", int'(err_code), 2);
    pre.delete();

    // Length out of range both ends.
    pay.delete();
    run_frame("len_513", 1'b1, 513, -1, -1, 0, 0, 1'b0);
    run_frame("len_0", 1'b1, 0, -1, -1, 0, 0, 1'b0);

    // Idle timeout mid-payload.
    pulse_start();
    send(8'h55, 0); send(8'h00, 0); send(8'h04, 0);
    push(K_DATA, 1, 0);
    push(K_ERR, 1, 1);
    send(8'h01, 0);
    drain("timeout", TO + 40);
    chk("timeout_cnt", int'(byte_cnt), 1);

    // Gaps just under the timeout keep the frame alive.
    rand_pay(3);
    run_frame("long_gap", 1'b1, 3, -1, -1, TO - 5, TO - 5, 1'b0);

    // FIFO full drops the byte and errors; i_start then restarts in SYNC.
    rand_pay(6);
    run_frame("fifo_full", 1'b1, 6, -1, 2, 0, 1, 1'b0);
    pulse_start();
    chk("restart_err", int'(err), 0);
    chk("restart_busy", int'(busy), 1);
    rand_pay(4);
    run_frame("after_restart", 1'b0, 4, -1, -1, 0, 2, 1'b0);

    // i_start mid-payload must not disturb the frame.
    rand_pay(8);
    run_frame("mid_start", 1'b1, 8, -1, -1, 0, 1, 1'b1);

    // Maximum length frame.
    rand_pay(MAXL);
    run_frame("len_max", 1'b1, MAXL, -1, -1, 0, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      pre.delete();
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) pre.push_back(rand_not_sync());
      n = $urandom_range(24, 1);
      rand_pay(n);
      run_frame("rand", 1'b1, n, ($urandom_range(1, 0) == 1) ? -1 : int'($urandom_range(255, 0)),
                ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1,
                0, 3, 1'b0);
    end
    pre.delete();

    // Reset mid-payload aborts at once; later bytes ignored until i_start.
    pulse_start();
    send(8'h55, 0); send(8'h00, 0); send(8'h0A, 0);
    for (int i = 0; i < 4; i++) begin
      push(K_DATA, 8'hC0 + i, 0);
      send(8'hC0 + i, 0);
    end
    drain("pre_reset", 10);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hE5;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_fifo_valid", int'(fifo_valid), 0);
    chk("mrst_fifo_data", int'(fifo_data), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_err", int'(err), 0);
    chk("mrst_err_code", int'(err_code), 0);
    chk("mrst_byte_cnt", int'(byte_cnt), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 0); send(8'h00, 0); send(8'h01, 0); send(8'h42, 0); send(8'h42, 0);
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_cnt", int'(byte_cnt), 0);

    // A clean frame still works afterwards.
    rand_pay(5);
    run_frame("post_rst_frame", 1'b1, 5, -1, -1, 0, 2, 1'b0);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL final_queue: got %0d leftover events expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_load_ctrl.md
UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, 8'h55, frame start marker.
REQ-002 Parameter MAX_LEN, 512, maximum payload bytes (256 BRAM words x 2 bytes).
REQ-003 Parameter TIMEOUT_CYCLES, 1000000, maximum idle i_clk_wr cycles between bytes once a frame has started.
REQ-004 Reset is i_rst_n, asynchronous, active-low; clock is i_clk_wr.
REQ-005 i_clk_wr  input  1  write-domain clock (UART side, 100 MHz).
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_rx_valid  input  1  single-cycle strobe, UART byte received.
REQ-008 i_rx_data  input  8  received byte, valid with i_rx_valid.
REQ-009 i_start  input  1  single-cycle pulse that arms a load.
REQ-010 i_fifo_full  input  1  async FIFO full flag, write domain.
REQ-011 o_fifo_valid  output  1  payload byte write strobe to FIFO.
REQ-012 o_fifo_data  output  8  payload byte to FIFO.
REQ-013 o_busy  output  1  load in progress; holds CPU in reset.
REQ-014 o_done  output  1  single-cycle pulse, frame accepted.
REQ-015 o_err  output  1  sticky error flag.
REQ-016 o_err_code  output  2  error cause; meaningful only while o_err=1.
REQ-017 o_byte_cnt  output  16  payload bytes forwarded in the current or last frame.

Function
REQ-018 The FSM SHALL have states IDLE, SYNC, LEN_H, LEN_L, PAYLOAD, CSUM, DONE and ERR.
REQ-019 IDLE: on i_start go to SYNC, clear o_byte_cnt, length and checksum; ignore all i_rx_valid bytes.
REQ-020 SYNC: a byte equal to SYNC_BYTE moves to LEN_H; other bytes are discarded; no timeout applies.
REQ-021 LEN_H/LEN_L: capture length N big-endian, high byte first; after LEN_L go to PAYLOAD if 1<=N<=MAX_LEN, else go to ERR with code 2'b00.
REQ-022 PAYLOAD: each i_rx_valid with i_fifo_full=0 registers o_fifo_data=i_rx_data and o_fifo_valid=1 on the next cycle (latency 1), adds the byte mod 256 to the checksum, and increments o_byte_cnt.
REQ-023 PAYLOAD: i_rx_valid while i_fifo_full=1 drops the byte, keeps o_fifo_valid=0, and goes to ERR with code 2'b11.
REQ-024 PAYLOAD: after the Nth accepted byte go to CSUM.
REQ-025 CSUM: on the next byte, go to DONE if it equals the 8-bit checksum, else go to ERR with code 2'b10.
REQ-026 DONE: assert o_done for exactly one cycle, then go to IDLE.
REQ-027 ERR: set o_err=1 and latch o_err_code; remain until i_start, which clears o_err and goes to SYNC.
REQ-028 The timeout counter SHALL run in LEN_H, LEN_L, PAYLOAD and CSUM, restart on every i_rx_valid, and on reaching TIMEOUT_CYCLES go to ERR with code 2'b01.
REQ-029 o_busy SHALL be 1 exactly in SYNC, LEN_H, LEN_L, PAYLOAD and CSUM.
REQ-030 i_start SHALL be ignored outside IDLE and ERR.
REQ-031 o_fifo_valid SHALL be 1 at most one cycle per accepted payload byte and never outside PAYLOAD-accepted bytes.
REQ-032 o_byte_cnt SHALL hold its value in DONE, ERR and IDLE until the next i_start.
REQ-033 If i_rx_valid and a timeout expiry fall in the same cycle, the byte SHALL win and the counter SHALL restart.

Reset
REQ-034 While i_rst_n=0: state=IDLE, o_fifo_valid=0, o_fifo_data=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_byte_cnt=0, timeout counter=0, checksum=0.
REQ-035 Reset asserted mid-frame SHALL abort immediately with no further o_fifo_valid pulse; after release the block waits for a new i_start.

Verification
REQ-036 i_start; bytes 55,00,03,11,22,33,66 -> three o_fifo_valid pulses carrying 11,22,33; o_done pulse; o_byte_cnt=3; o_busy returns to 0.
REQ-037 i_start; bytes AA,55,00,01,7F,00 -> AA ignored; 7F forwarded; checksum mismatch; o_err=1, o_err_code=2'b10.
REQ-038 i_start; bytes 55,02,01 (N=513) -> ERR, code 2'b00, no o_fifo_valid pulse.
REQ-039 i_start; 55,00,04,01, then no bytes for TIMEOUT_CYCLES (bench parameter set to 100) -> ERR, code 2'b01, o_byte_cnt=1.
REQ-040 In PAYLOAD with i_fifo_full=1, send a byte -> no o_fifo_valid pulse; ERR code 2'b11; a following i_start clears o_err and returns to SYNC.
REQ-041 Assert i_rst_n=0 during PAYLOAD -> all outputs at reset values at once; bytes sent before the next i_start are ignored.
